andor_unit_sched: RTL

Round-robin scheduler that shares one AndOr gate unit (X = A & B, Y = B | C, fixed propagation delay) among NREQ requesters. Each requester submits a 3-bit operand triple {A,B,C} over a valid/ready handshake. The scheduler drives the triple onto the shared unit, waits a programmable settle window covering the unit's delay, captures X/Y, and returns them tagged with the requester ID. It sits between the requester ports and the single combinational AndOr instance.

---
 rtl/andor_unit_sched_if.sv | 35 +++
 rtl/andor_unit_sched.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/andor_unit_sched_if.sv
// Bus bundle for andor_unit_sched: requester handshake, shared AndOr unit pins and response channel.
// The master modport is the scheduler side; the slave modport is the requesters/unit/consumer side.
interface andor_unit_sched_if #(
    parameter int NREQ = 4
);
    localparam int IDW = $clog2(NREQ);

    logic [NREQ-1:0]   req_valid;
    logic [3*NREQ-1:0] req_abc;
    logic [NREQ-1:0]   req_ready;
    logic              unit_a;
    logic              unit_b;
    logic              unit_c;
    logic              unit_x;
    logic              unit_y;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [IDW-1:0]    rsp_id;
    logic              rsp_x;
    logic              rsp_y;
    logic              rsp_err;
    logic              err_sticky;

    modport master (
        input  req_valid, req_abc, unit_x, unit_y, rsp_ready,
        output req_ready, unit_a, unit_b, unit_c,
               rsp_valid, rsp_id, rsp_x, rsp_y, rsp_err, err_sticky
    );

    modport slave (
        output req_valid, req_abc, unit_x, unit_y, rsp_ready,
        input  req_ready, unit_a, unit_b, unit_c,
               rsp_valid, rsp_id, rsp_x, rsp_y, rsp_err, err_sticky
    );
endinterface

// File: rtl/andor_unit_sched.sv
// Round-robin scheduler sharing one combinational AndOr unit (X = A&B, Y = B|C) among NREQ requesters.
// Optional result self-check is enabled by defining ANDOR_SCHED_SELFCHECK_EN.
module andor_unit_sched #(
    parameter int NREQ          = 4,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    andor_unit_sched_if.master bus
);
    localparam int IDW = $clog2(NREQ);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [IDW-1:0]  r_ptr;
    logic [3:0]      r_cnt;
    logic            r_a;
    logic            r_b;
    logic            r_c;
    logic [IDW-1:0]  r_rsp_id;
    logic            r_rsp_x;
    logic            r_rsp_y;
    logic [IDW-1:0]  w_win;
    logic            w_found;
    logic [2:0]      w_abc;
    logic            w_hs_req;
    logic            w_capture;
    logic [NREQ-1:0] w_req_ready;
    logic            w_rsp_valid;

    function automatic logic [IDW-1:0] rr_idx(input logic [IDW-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= NREQ) s = s - NREQ;
        return IDW'(s);
    endfunction

    function automatic logic [IDW-1:0] next_ptr(input logic [IDW-1:0] win);
        if (int'(win) == NREQ - 1) return '0;
        return win + 1'b1;
    endfunction

    // First valid requester at or after ptr, wrapping modulo NREQ
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!w_found && bus.req_valid[rr_idx(r_ptr, k)]) begin
                w_found = 1'b1;
                w_win   = rr_idx(r_ptr, k);
            end
        end
    end

    assign w_abc     = bus.req_abc[3*int'(w_win) +: 3];
    assign w_hs_req  = (r_state == S_IDLE) && w_found;
    assign w_capture = (r_state == S_SETTLE) && (r_cnt == 4'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (w_found)        w_state_nxt = S_SETTLE;
            S_SETTLE: if (r_cnt == 4'd1)  w_state_nxt = S_RESP;
            S_RESP:   if (bus.rsp_ready)  w_state_nxt = S_IDLE;
            default:                      w_state_nxt = S_IDLE;
        endcase
    end

    // Grant is gated by rst_n so req_ready reads 0 for the whole reset interval
    always_comb begin
        w_req_ready = '0;
        w_rsp_valid = 1'b0;
        case (r_state)
            S_IDLE:   if (w_found && rst_n) w_req_ready[w_win] = 1'b1;
            S_RESP:   w_rsp_valid = 1'b1;
            default:  ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr    <= '0;
            r_cnt    <= '0;
            r_a      <= 1'b0;
            r_b      <= 1'b0;
            r_c      <= 1'b0;
            r_rsp_id <= '0;
            r_rsp_x  <= 1'b0;
            r_rsp_y  <= 1'b0;
        end else begin
            if (w_hs_req) begin
                {r_a, r_b, r_c} <= w_abc;
                r_rsp_id        <= w_win;
                r_ptr           <= next_ptr(w_win);
                r_cnt           <= 4'(SETTLE_CYCLES);
            end else if (r_state == S_SETTLE) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_capture) begin
                r_rsp_x <= bus.unit_x;
                r_rsp_y <= bus.unit_y;
            end
        end
    end

`ifdef ANDOR_SCHED_SELFCHECK_EN
    logic r_rsp_err;
    logic r_err_sticky;
    logic w_mismatch;

    // Checked against the latched operands, which are what the unit actually sees
    assign w_mismatch = (bus.unit_x != (r_a & r_b)) || (bus.unit_y != (r_b | r_c));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_err    <= 1'b0;
            r_err_sticky <= 1'b0;
        end else if (w_capture) begin
            r_rsp_err <= w_mismatch;
            if (w_mismatch) r_err_sticky <= 1'b1;
        end
    end

    assign bus.rsp_err    = r_rsp_err;
    assign bus.err_sticky = r_err_sticky;
`else
    assign bus.rsp_err    = 1'b0;
    assign bus.err_sticky = 1'b0;
`endif

    assign bus.req_ready = w_req_ready;
    assign bus.unit_a    = r_a;
    assign bus.unit_b    = r_b;
    assign bus.unit_c    = r_c;
    assign bus.rsp_valid = w_rsp_valid;
    assign bus.rsp_id    = r_rsp_id;
    assign bus.rsp_x     = r_rsp_x;
    assign bus.rsp_y     = r_rsp_y;
endmodule
